// File: rtl/zeroriscy_d_sram_arb_if.sv
// Requester-side bus of the data SRAM arbiter (one instance per requester).
//   req/addr/we/be/wdata : request, held stable by the requester until gnt
//   gnt                  : combinational grant from the arbiter
//   rvalid/rdata/err     : response, one cycle after gnt
// master = requester (core LSU or DMA), slave = arbiter.
interface zeroriscy_d_sram_arb_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/zeroriscy_d_sram_arb.sv
// Arbiter/sequencer for the 8-bank data SRAM (8 x 4K x 32b, 128 KB).
// Round-robin between the core LSU and DMA, with DMA burst locking bounded
// by DMA_MAX_BURST. Responses come back one cycle after grant.
//   clk, rst_n     : clock, synchronous active-low reset
//   core, dma      : requester buses (slave side)
//   dma_lock       : DMA asks to keep priority for its next request
//   sram_addr      : row to every bank
//   sram_cs        : one-hot bank select
//   sram_we/be/din : write strobe, byte enables, write data
//   sram_dout      : 256b read bus, bank i at [32*(7-i) +: 32]
module zeroriscy_d_sram_arb #(
  parameter logic [31:0] BASE_ADDR     = 32'h0010_0000,
  parameter int unsigned DMA_MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  zeroriscy_d_sram_arb_if.slave   core,
  zeroriscy_d_sram_arb_if.slave   dma,
  input  logic                    dma_lock,
  output logic [11:0]             sram_addr,
  output logic [7:0]              sram_cs,
  output logic                    sram_we,
  output logic [3:0]              sram_be,
  output logic [31:0]             sram_din,
  input  logic [255:0]            sram_dout
);

  localparam logic [31:0] WIN_BYTES    = 32'h0002_0000;
  localparam logic [3:0]  BURST_RELOAD = 4'(DMA_MAX_BURST - 1);

  logic        rr_last;     // 0: core won last, 1: DMA won last
  logic [3:0]  burst_cnt;
  logic        dma_win, core_win, any_gnt;
  logic [31:0] sel_addr, sel_wdata, off;
  logic        sel_we, in_win;
  logic [3:0]  sel_be;
  logic [2:0]  bank;

  logic        resp_core, resp_dma, resp_err, resp_rd;
  logic [2:0]  resp_bank;
  logic [31:0] bank_word [8];
  logic [31:0] rd_word;

  // DMA takes a tie while it holds a live burst lock, or when core won last.
  always_comb begin
    dma_win  = dma.req & (~core.req | (dma_lock & (burst_cnt != 4'd0)) | ~rr_last);
    core_win = core.req & ~dma_win;
  end

  // Reset gates grants so nothing reaches the SRAM while rst_n is low.
  assign core.gnt = rst_n & core_win;
  assign dma.gnt  = rst_n & dma_win;
  assign any_gnt  = core.gnt | dma.gnt;

  // Decode only the selected request; the loser's address is irrelevant.
  always_comb begin
    sel_addr  = dma_win ? dma.addr  : core.addr;
    sel_we    = dma_win ? dma.we    : core.we;
    sel_be    = dma_win ? dma.be    : core.be;
    sel_wdata = dma_win ? dma.wdata : core.wdata;
    off       = sel_addr - BASE_ADDR;
    in_win    = (sel_addr >= BASE_ADDR) && (off < WIN_BYTES);
    bank      = off[4:2];
  end

  assign sram_addr = off[16:5];
  assign sram_cs   = (any_gnt & in_win) ? (8'b1 << bank) : 8'b0;
  assign sram_we   = any_gnt & in_win & sel_we;
  assign sram_be   = sel_be;
  assign sram_din  = sel_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last   <= 1'b1;
      burst_cnt <= 4'd0;
      resp_core <= 1'b0;
      resp_dma  <= 1'b0;
      resp_bank <= 3'd0;
      resp_err  <= 1'b0;
      resp_rd   <= 1'b0;
    end else begin
      if (core.gnt)     rr_last <= 1'b0;
      else if (dma.gnt) rr_last <= 1'b1;

      // Lock only counts down while the core is actually being held off.
      if (core.gnt || !dma_lock)
        burst_cnt <= 4'd0;
      else if (dma.gnt && core.req)
        burst_cnt <= (burst_cnt == 4'd0) ? BURST_RELOAD : burst_cnt - 4'd1;

      resp_core <= core.gnt;
      resp_dma  <= dma.gnt;
      resp_bank <= bank;
      resp_err  <= any_gnt & ~in_win;
      resp_rd   <= any_gnt & in_win & ~sel_we;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_bank
    assign bank_word[i] = sram_dout[32*(7-i) +: 32];
  end

  assign rd_word = resp_rd ? bank_word[resp_bank] : 32'h0;

  // Responses are also gated by rst_n so one in flight at reset is dropped.
  assign core.rvalid = rst_n & resp_core;
  assign core.rdata  = (rst_n & resp_core) ? rd_word : 32'h0;
  assign core.err    = rst_n & resp_core & resp_err;
  assign dma.rvalid  = rst_n & resp_dma;
  assign dma.rdata   = (rst_n & resp_dma) ? rd_word : 32'h0;
  assign dma.err     = rst_n & resp_dma & resp_err;

endmodule
